// File: rtl/uart_baud_ctrl.sv
// uart_baud_ctrl
//  Baud tick scheduler for the UART. A free-running counter produces one oversample tick
//  every div_o clocks and one bit tick every OVSAMP oversample ticks. A new divisor from
//  the config path is held in a shadow register. It takes effect only in a cycle where
//  the RX/TX samplers report idle (busy_i low), so no frame sees a rate change mid-bit.
//  Optional feature macro: UART_AUTOBAUD_EN. When it is defined, the block adds a
//  pulse-width autobaud measurement on rx_i. When it is undefined, rx_i and ab_start_i
//  are ignored and ab_done_o is tied low.
//  OVSAMP is expected to be a power of two.
module uart_baud_ctrl #(
    parameter int unsigned CLK_RATE  = 32'd100_000_000,
    parameter int unsigned BAUD_RATE = 32'd3_000_000,
    parameter int unsigned OVSAMP    = 32'd8,
    parameter int unsigned DIV_W     = 32'd16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             cfg_valid_i,
    input  logic [DIV_W-1:0] cfg_div_i,
    output logic             cfg_ready_o,
    input  logic             busy_i,
    output logic             ovsamp_tick_o,
    output logic             bit_tick_o,
    output logic [DIV_W-1:0] div_o,
    output logic             pending_o,
    input  logic             rx_i,
    input  logic             ab_start_i,
    output logic             ab_done_o
);

    // Reset divisor: clk cycles per oversample tick, never below 1.
    function automatic logic [DIV_W-1:0] bddiv(input int unsigned clk_rate,
                                               input int unsigned baud_rate);
        int unsigned quot;
        quot = clk_rate / (baud_rate * OVSAMP);
        if (quot == 32'd0) begin
            quot = 32'd1;
        end
        return quot[DIV_W-1:0];
    endfunction

    // A divisor of zero would stall the counter, so it is promoted to one.
    function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
        return (d == {DIV_W{1'b0}}) ? {{(DIV_W-1){1'b0}}, 1'b1} : d;
    endfunction

    localparam int unsigned      OV_SH    = (OVSAMP > 32'd1) ? $clog2(OVSAMP) : 32'd0;
    localparam int unsigned      PH_W     = (OV_SH > 32'd0) ? OV_SH : 32'd1;
    localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
    localparam logic [DIV_W-1:0] DIV_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};
    localparam logic [DIV_W-1:0] RST_DIV  = bddiv(CLK_RATE, BAUD_RATE);
    localparam logic [PH_W-1:0]  PH_ZERO  = {PH_W{1'b0}};
    localparam logic [PH_W-1:0]  PH_ONE   = {{(PH_W-1){1'b0}}, 1'b1};
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(OVSAMP - 32'd1);

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_PEND = 2'd1;
`ifdef UART_AUTOBAUD_EN
    localparam logic [1:0] ST_AB_WAIT = 2'd2;
    localparam logic [1:0] ST_AB_MEAS = 2'd3;

    localparam int unsigned       MEAS_W   = DIV_W + 32'd3;
    localparam logic [MEAS_W-1:0] MEAS_ONE = {{(MEAS_W-1){1'b0}}, 1'b1};
    localparam logic [MEAS_W-1:0] MEAS_MAX = {MEAS_W{1'b1}};
`endif

    logic [1:0]       state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] shadow_q, shadow_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [PH_W-1:0]  phase_q, phase_d;

    logic             cnt_last_s;
    logic             apply_s;
    logic [DIV_W-1:0] apply_div_s;
    logic             ovsamp_tick_s;

`ifdef UART_AUTOBAUD_EN
    logic              rx_q;
    logic [MEAS_W-1:0] meas_q, meas_d;
    logic              ab_done_q, ab_done_d;
    logic [MEAS_W-1:0] meas_shift_s;
    logic [DIV_W-1:0]  ab_div_s;

    assign meas_shift_s = meas_q >> OV_SH;
    assign ab_div_s     = clamp_div(meas_shift_s[DIV_W-1:0]);
`else
    logic unused_s;
    assign unused_s = ^{rx_i, ab_start_i};
`endif

    // Last count of the oversample period; >= guards against any out-of-range count.
    assign cnt_last_s    = (cnt_q >= (div_q - DIV_ONE));
    // The cycle that loads a new divisor restarts the period and emits no tick.
    assign ovsamp_tick_s = cnt_last_s & ~apply_s;

    // Decide whether this cycle loads a new divisor, and from which source.
    always_comb begin
        apply_s     = 1'b0;
        apply_div_s = div_q;
        if ((state_q == ST_PEND) && !busy_i) begin
            apply_s     = 1'b1;
            apply_div_s = shadow_q;
        end
`ifdef UART_AUTOBAUD_EN
        else if ((state_q == ST_AB_MEAS) && rx_i) begin
            apply_s     = 1'b1;
            apply_div_s = ab_div_s;
        end
`endif
        else begin
            apply_s     = 1'b0;
            apply_div_s = div_q;
        end
    end

    // Next divisor, cycle counter and oversample phase.
    always_comb begin
        div_d   = div_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (apply_s) begin
            div_d   = apply_div_s;
            cnt_d   = DIV_ZERO;
            phase_d = PH_ZERO;
        end else begin
            div_d = div_q;
            if (cnt_last_s) begin
                cnt_d = DIV_ZERO;
            end else begin
                cnt_d = cnt_q + DIV_ONE;
            end
            if (ovsamp_tick_s) begin
                phase_d = (phase_q == PH_LAST) ? PH_ZERO : (phase_q + PH_ONE);
            end else begin
                phase_d = phase_q;
            end
        end
    end

    // Control FSM: config handshake, idle-gated switch and optional autobaud.
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
`ifdef UART_AUTOBAUD_EN
        meas_d    = meas_q;
        ab_done_d = 1'b0;
`endif
        case (state_q)
            ST_RUN: begin
                if (cfg_valid_i) begin
                    shadow_d = clamp_div(cfg_div_i);
                    state_d  = ST_PEND;
                end
`ifdef UART_AUTOBAUD_EN
                else if (ab_start_i) begin
                    state_d = ST_AB_WAIT;
                end
`endif
                else begin
                    state_d = ST_RUN;
                end
            end
            ST_PEND: begin
                if (!busy_i) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_PEND;
                end
            end
`ifdef UART_AUTOBAUD_EN
            ST_AB_WAIT: begin
                if (rx_q && !rx_i) begin
                    meas_d  = MEAS_ONE;
                    state_d = ST_AB_MEAS;
                end else begin
                    state_d = ST_AB_WAIT;
                end
            end
            ST_AB_MEAS: begin
                if (rx_i) begin
                    ab_done_d = 1'b1;
                    state_d   = ST_RUN;
                end else begin
                    meas_d  = (meas_q == MEAS_MAX) ? MEAS_MAX : (meas_q + MEAS_ONE);
                    state_d = ST_AB_MEAS;
                end
            end
`endif
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Core state registers; reset restores the build-time divisor and drops any request.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= ST_RUN;
            div_q    <= RST_DIV;
            shadow_q <= DIV_ZERO;
            cnt_q    <= DIV_ZERO;
            phase_q  <= PH_ZERO;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
        end
    end

`ifdef UART_AUTOBAUD_EN
    // Autobaud line history (idle high), pulse-width counter and completion pulse.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rx_q      <= 1'b1;
            meas_q    <= {MEAS_W{1'b0}};
            ab_done_q <= 1'b0;
        end else begin
            rx_q      <= rx_i;
            meas_q    <= meas_d;
            ab_done_q <= ab_done_d;
        end
    end

    assign ab_done_o = ab_done_q;
`else
    assign ab_done_o = 1'b0;
`endif

    assign cfg_ready_o   = rstn & (state_q == ST_RUN);
    assign pending_o     = (state_q == ST_PEND);
    assign div_o         = div_q;
    assign ovsamp_tick_o = ovsamp_tick_s;
    assign bit_tick_o    = ovsamp_tick_s & (phase_q == PH_LAST);

endmodule

// File: tb/tb_uart_baud_ctrl.sv
// tb_uart_baud_ctrl
//  Directed stimulus with a cycle-stamped scoreboard. Stimulus pushes the expected value of an
//  output for a given cycle. A monitor samples at each falling edge and pops every entry due in
//  that cycle. Cycle k is the interval after the k-th rising clock edge.
module tb_uart_baud_ctrl;

    localparam int DIV_W = 16;

    localparam int K_TICK = 0;
    localparam int K_BIT  = 1;
    localparam int K_DIV  = 2;
    localparam int K_PEND = 3;
    localparam int K_RDY  = 4;
    localparam int K_ABD  = 5;

    typedef struct {
        int cyc;
        int kind;
        int val;
    } exp_t;

    logic             clk;
    logic             rstn;
    logic             cfg_valid_i;
    logic [DIV_W-1:0] cfg_div_i;
    logic             cfg_ready_o;
    logic             busy_i;
    logic             ovsamp_tick_o;
    logic             bit_tick_o;
    logic [DIV_W-1:0] div_o;
    logic             pending_o;
    logic             rx_i;
    logic             ab_start_i;
    logic             ab_done_o;

    exp_t        sb_q[$];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    logic        done_req = 1'b0;
    logic        done_ack = 1'b0;
    logic [31:0] mon_act;
    logic [31:0] mon_exp;

    uart_baud_ctrl #(
        .CLK_RATE (100_000_000),
        .BAUD_RATE(3_000_000),
        .OVSAMP   (8),
        .DIV_W    (DIV_W)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .cfg_valid_i  (cfg_valid_i),
        .cfg_div_i    (cfg_div_i),
        .cfg_ready_o  (cfg_ready_o),
        .busy_i       (busy_i),
        .ovsamp_tick_o(ovsamp_tick_o),
        .bit_tick_o   (bit_tick_o),
        .div_o        (div_o),
        .pending_o    (pending_o),
        .rx_i         (rx_i),
        .ab_start_i   (ab_start_i),
        .ab_done_o    (ab_done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] observe(input int kind);
        case (kind)
            K_TICK:  observe = {31'd0, ovsamp_tick_o};
            K_BIT:   observe = {31'd0, bit_tick_o};
            K_DIV:   observe = {16'd0, div_o};
            K_PEND:  observe = {31'd0, pending_o};
            K_RDY:   observe = {31'd0, cfg_ready_o};
            K_ABD:   observe = {31'd0, ab_done_o};
            default: observe = 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic string kname(input int kind);
        case (kind)
            K_TICK:  kname = "ovsamp_tick";
            K_BIT:   kname = "bit_tick";
            K_DIV:   kname = "div";
            K_PEND:  kname = "pending";
            K_RDY:   kname = "cfg_ready";
            K_ABD:   kname = "ab_done";
            default: kname = "unknown";
        endcase
    endfunction

    task automatic push(input int kind, input int c, input int v);
        exp_t e;
        e.cyc  = c;
        e.kind = kind;
        e.val  = v;
        sb_q.push_back(e);
    endtask

    // Periodic pulse expectation: high at first, first+per, ... inside [c0, c1].
    task automatic push_win(input int kind, input int c0, input int c1,
                            input int first, input int per);
        for (int c = c0; c <= c1; c++) begin
            push(kind, c, ((c >= first) && (((c - first) % per) == 0)) ? 1 : 0);
        end
    endtask

    task automatic push_const(input int kind, input int c0, input int c1, input int v);
        for (int c = c0; c <= c1; c++) begin
            push(kind, c, v);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: compare every expectation due this cycle, flag any that were never reached.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = sb_q.size() - 1; i >= 0; i--) begin
                if (sb_q[i].cyc == cyc) begin
                    mon_act = observe(sb_q[i].kind);
                    mon_exp = sb_q[i].val;
                    checks  = checks + 1;
                    if (mon_act !== mon_exp) begin
                        failures = failures + 1;
                        $display("FAIL %s cyc=%0d actual=%0d required=%0d",
                                 kname(sb_q[i].kind), cyc, mon_act, mon_exp);
                    end
                    sb_q.delete(i);
                end else if (sb_q[i].cyc < cyc) begin
                    checks   = checks + 1;
                    failures = failures + 1;
                    $display("FAIL stale_%s cyc=%0d actual=unchecked required=%0d",
                             kname(sb_q[i].kind), sb_q[i].cyc, sb_q[i].val);
                    sb_q.delete(i);
                end
            end
            if (done_req && !done_ack) begin
                checks = checks + 1;
                if (sb_q.size() != 0) begin
                    failures = failures + 1;
                    $display("FAIL drain actual=%0d required=0 pending expectations", sb_q.size());
                end
                done_ack = 1'b1;
            end
        end
    end

    // Stimulus
    initial begin
        int r;
        int t;

        rstn        = 1'b0;
        cfg_valid_i = 1'b0;
        cfg_div_i   = 16'd0;
        busy_i      = 1'b0;
        rx_i        = 1'b1;
        ab_start_i  = 1'b0;

        // Reset values while rstn is held low.
        push(K_DIV, 2, 4);
        push(K_PEND, 2, 0);
        push(K_TICK, 2, 0);
        push(K_BIT, 2, 0);
        push(K_ABD, 2, 0);
        step(3);
        r    = cyc;
        rstn = 1'b1;

        // Defaults: tick every 4 clocks, bit tick every 32.
        push(K_RDY, r, 1);
        push_win(K_TICK, r, r + 69, r + 3, 4);
        push_win(K_BIT, r, r + 69, r + 31, 32);
        push_const(K_ABD, r, r + 69, 0);
        push(K_DIV, r + 40, 4);
        push(K_PEND, r + 40, 0);
        step(70);

        // Handshake while busy: old period continues, and a second offer while pending is ignored.
        t           = cyc;
        cfg_valid_i = 1'b1;
        cfg_div_i   = 16'd6;
        busy_i      = 1'b1;
        push(K_RDY, t, 1);
        push_win(K_TICK, t + 1, t + 49, r + 3, 4);
        push(K_TICK, t + 50, 0);
        push(K_BIT, t + 50, 0);
        push(K_PEND, t + 1, 1);
        push(K_PEND, t + 49, 1);
        push(K_PEND, t + 50, 1);
        push(K_PEND, t + 51, 0);
        push(K_RDY, t + 1, 0);
        push(K_RDY, t + 50, 0);
        push(K_RDY, t + 51, 1);
        push(K_DIV, t + 50, 4);
        push(K_DIV, t + 51, 6);
        push_win(K_TICK, t + 51, t + 140, t + 56, 6);
        push_win(K_BIT, t + 51, t + 140, t + 98, 48);
        step(1);
        cfg_valid_i = 1'b0;
        step(4);
        cfg_valid_i = 1'b1;
        cfg_div_i   = 16'd20;
        step(2);
        cfg_valid_i = 1'b0;
        step(43);
        busy_i = 1'b0;
        step(91);

        // Idle switch to 10: div valid at T+2, first tick at T+11, bit period 80.
        t           = cyc;
        cfg_valid_i = 1'b1;
        cfg_div_i   = 16'd10;
        push(K_RDY, t, 1);
        push(K_PEND, t + 1, 1);
        push(K_RDY, t + 1, 0);
        push(K_TICK, t + 1, 0);
        push(K_BIT, t + 1, 0);
        push(K_DIV, t + 1, 6);
        push(K_DIV, t + 2, 10);
        push(K_RDY, t + 2, 1);
        push(K_PEND, t + 2, 0);
        push_win(K_TICK, t + 2, t + 170, t + 11, 10);
        push_win(K_BIT, t + 2, t + 170, t + 81, 80);
        step(1);
        cfg_valid_i = 1'b0;
        step(170);

        // Divisor 0 is treated as 1: tick every cycle, bit tick every 8.
        t           = cyc;
        cfg_valid_i = 1'b1;
        cfg_div_i   = 16'd0;
        push(K_DIV, t + 1, 10);
        push(K_DIV, t + 2, 1);
        push_win(K_TICK, t + 2, t + 40, t + 2, 1);
        push_win(K_BIT, t + 2, t + 40, t + 9, 8);
        step(1);
        cfg_valid_i = 1'b0;
        step(40);

        // Reset while pending: the shadowed 10 must never be applied.
        t           = cyc;
        cfg_valid_i = 1'b1;
        cfg_div_i   = 16'd10;
        busy_i      = 1'b1;
        push(K_PEND, t + 1, 1);
        push(K_DIV, t + 5, 1);
        step(1);
        cfg_valid_i = 1'b0;
        step(5);
        rstn   = 1'b0;
        busy_i = 1'b0;
        step(2);
        rstn = 1'b1;
        r    = cyc;
        push(K_DIV, r, 4);
        push(K_PEND, r, 0);
        push(K_RDY, r, 1);
        push(K_DIV, r + 1, 4);
        push(K_PEND, r + 1, 0);
        push(K_DIV, r + 20, 4);
        push(K_DIV, r + 40, 4);
        push_win(K_TICK, r, r + 40, r + 3, 4);
        push_win(K_BIT, r, r + 40, r + 31, 32);
        step(41);

`ifdef UART_AUTOBAUD_EN
        // Autobaud: 800 low clocks -> divisor 100.
        t          = cyc;
        ab_start_i = 1'b1;
        push(K_RDY, t, 1);
        push(K_RDY, t + 1, 0);
        step(1);
        ab_start_i = 1'b0;
        step(2);
        rx_i = 1'b0;
        step(800);
        rx_i = 1'b1;
        push(K_TICK, t + 803, 0);
        push(K_DIV, t + 803, 4);
        push(K_ABD, t + 803, 0);
        push(K_DIV, t + 804, 100);
        push(K_ABD, t + 804, 1);
        push(K_ABD, t + 805, 0);
        push(K_RDY, t + 804, 1);
        push_win(K_TICK, t + 804, t + 1010, t + 903, 100);
        step(210);

        // Autobaud: 3 low clocks -> divisor clamps to 1.
        t          = cyc;
        ab_start_i = 1'b1;
        step(1);
        ab_start_i = 1'b0;
        step(1);
        rx_i = 1'b0;
        step(3);
        rx_i = 1'b1;
        push(K_DIV, t + 6, 1);
        push(K_ABD, t + 6, 1);
        push(K_ABD, t + 7, 0);
        step(10);
`endif

        step(2);
        done_req = 1'b1;
        for (int i = 0; (i < 20) && !done_ack; i++) begin
            step(1);
        end
        if (!done_ack) begin
            $display("FAIL monitor_drain actual=no_ack required=ack");
            $fatal(1);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
